// File: rtl/fft_input_buffer_if.sv
// Streaming handshake bundle for fft_input_buffer: natural-order sample input and
// butterfly-pair output (x[k], x[k+N/2]) with frame markers.
interface fft_input_buffer_if #(
  parameter int unsigned DW = 32
);
  logic          flush;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] din_re;
  logic [DW-1:0] din_im;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout_a_re;
  logic [DW-1:0] dout_a_im;
  logic [DW-1:0] dout_b_re;
  logic [DW-1:0] dout_b_im;
  logic          dout_first;
  logic          dout_last;

  modport master (
    output flush, din_valid, din_re, din_im, dout_ready,
    input  din_ready, dout_valid, dout_a_re, dout_a_im, dout_b_re, dout_b_im,
    input  dout_first, dout_last
  );

  modport slave (
    input  flush, din_valid, din_re, din_im, dout_ready,
    output din_ready, dout_valid, dout_a_re, dout_a_im, dout_b_re, dout_b_im,
    output dout_first, dout_last
  );
endinterface

// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer: collects N natural-order samples per bank, then reads each full
// bank out as N/2 registered pairs (x[k], x[k+N/2]).
module fft_input_buffer #(
  parameter int unsigned DW = 32,
  parameter int unsigned N  = 64
) (
  input logic                clk,
  input logic                rst,
  fft_input_buffer_if.slave  bus
);
  localparam int unsigned AW  = $clog2(N);
  localparam int unsigned RdW = AW - 1;

  logic [DW-1:0] mem_re [2][N];
  logic [DW-1:0] mem_im [2][N];

  logic [1:0]     full_q, full_d;
  logic           wr_bank_q, rd_bank_q;
  logic [AW-1:0]  wr_cnt_q;
  logic [RdW-1:0] rd_cnt_q;

  logic          dout_valid_q, dout_first_q, dout_last_q;
  logic [DW-1:0] dout_a_re_q, dout_a_im_q, dout_b_re_q, dout_b_im_q;

  logic din_ready, wr_fire, wr_wrap, load, rd_wrap;

  always_comb begin
    din_ready = rst & ~full_q[wr_bank_q];
    wr_fire   = bus.din_valid & din_ready & ~bus.flush;
    wr_wrap   = wr_fire & (wr_cnt_q == AW'(N - 1));
    load      = full_q[rd_bank_q] & (~dout_valid_q | bus.dout_ready);
    rd_wrap   = load & (rd_cnt_q == RdW'(N / 2 - 1));
    // Completing one bank and releasing the other can coincide; both must land.
    full_d = full_q;
    if (wr_wrap) full_d[wr_bank_q] = 1'b1;
    if (rd_wrap) full_d[rd_bank_q] = 1'b0;
  end

  // Sample storage is never reset; a bank is only read once it is full.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_re[wr_bank_q][wr_cnt_q] <= bus.din_re;
      mem_im[wr_bank_q][wr_cnt_q] <= bus.din_im;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q       <= 2'b00;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_a_re_q  <= '0;
      dout_a_im_q  <= '0;
      dout_b_re_q  <= '0;
      dout_b_im_q  <= '0;
    end else begin
      full_q <= full_d;
      if (bus.flush) begin
        wr_cnt_q <= '0;
      end else if (wr_fire) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (wr_wrap) wr_bank_q <= ~wr_bank_q;
      end
      if (load) begin
        dout_valid_q <= 1'b1;
        dout_a_re_q  <= mem_re[rd_bank_q][{1'b0, rd_cnt_q}];
        dout_a_im_q  <= mem_im[rd_bank_q][{1'b0, rd_cnt_q}];
        dout_b_re_q  <= mem_re[rd_bank_q][{1'b1, rd_cnt_q}];
        dout_b_im_q  <= mem_im[rd_bank_q][{1'b1, rd_cnt_q}];
        dout_first_q <= (rd_cnt_q == '0);
        dout_last_q  <= rd_wrap;
        rd_cnt_q     <= rd_cnt_q + 1'b1;
        if (rd_wrap) rd_bank_q <= ~rd_bank_q;
      end else if (bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_a_re  = dout_a_re_q;
  assign bus.dout_a_im  = dout_a_im_q;
  assign bus.dout_b_re  = dout_b_re_q;
  assign bus.dout_b_im  = dout_b_im_q;
  assign bus.dout_first = dout_first_q;
  assign bus.dout_last  = dout_last_q;
endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed bench for fft_input_buffer (DW=32, N=64) with an output-pair scoreboard and
// a hold-while-stalled monitor.
module tb_fft_input_buffer;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 64;

  typedef struct packed {
    logic [DW-1:0] a_re;
    logic [DW-1:0] a_im;
    logic [DW-1:0] b_re;
    logic [DW-1:0] b_im;
    logic          first;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_input_buffer_if #(.DW(DW)) bus ();

  fft_input_buffer #(.DW(DW), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    beats   = 0;
  bit    rand_rdy = 1'b0;
  beat_t exp_q[$];

  function automatic beat_t cur_beat();
    beat_t b;
    b.a_re  = bus.dout_a_re;
    b.a_im  = bus.dout_a_im;
    b.b_re  = bus.dout_b_re;
    b.b_im  = bus.dout_b_im;
    b.first = bus.dout_first;
    b.last  = bus.dout_last;
    return b;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected pairs for a frame whose sample i is (base_re+i, base_im+i).
  task automatic push_frame(input logic [DW-1:0] base_re, input logic [DW-1:0] base_im);
    beat_t b;
    for (int k = 0; k < N / 2; k++) begin
      b.a_re  = base_re + DW'(k);
      b.a_im  = base_im + DW'(k);
      b.b_re  = base_re + DW'(k + N / 2);
      b.b_im  = base_im + DW'(k + N / 2);
      b.first = (k == 0);
      b.last  = (k == N / 2 - 1);
      exp_q.push_back(b);
    end
  endtask

  // Entered and left at posedge+1; returns cycles spent waiting for din_ready.
  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, output int waits);
    bit got = 1'b0;
    waits = 0;
    bus.din_valid = 1'b1;
    bus.din_re    = re;
    bus.din_im    = im;
    while (!got && waits < 200) begin
      if (rand_rdy) bus.dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = bus.din_ready;
      @(posedge clk);
      #1;
      if (!got) waits++;
    end
    bus.din_valid = 1'b0;
    if (!got) check("send_timeout", 160'(got), 160'(1));
  endtask

  task automatic send_frame(input logic [DW-1:0] base_re, input logic [DW-1:0] base_im,
                            input int count, output int total_waits);
    int w;
    total_waits = 0;
    for (int i = 0; i < count; i++) begin
      send(base_re + DW'(i), base_im + DW'(i), w);
      total_waits += w;
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || bus.dout_valid) && guard < 1000) begin
      if (rand_rdy) bus.dout_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      guard++;
    end
    check(tag, 160'(exp_q.size()), 160'(0));
  endtask

  initial begin : monitor
    bit    prev_stall = 1'b0;
    beat_t prev, cur, e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = cur_beat();
        if (prev_stall) check("hold_stable", 160'(cur), 160'(prev));
        if (bus.dout_valid && bus.dout_ready) begin
          n_tests++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_extra: got beat %h want none", cur);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_beat", 160'(cur), 160'(e));
          end
          beats++;
        end
        prev_stall = bus.dout_valid && !bus.dout_ready;
        prev       = cur;
      end
    end
  end

  initial begin : stim
    int w, base, guard;
    bit saw;
    bus.flush      = 1'b0;
    bus.din_valid  = 1'b0;
    bus.din_re     = '0;
    bus.din_im     = '0;
    bus.dout_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_din_ready", 160'(bus.din_ready), 160'(0));
    check("rst_dout_valid", 160'(bus.dout_valid), 160'(0));
    check("rst_dout_data", 160'(cur_beat()), 160'(0));
    rst = 1'b1;
    #1;
    check("post_rst_din_ready", 160'(bus.din_ready), 160'(1));

    // Single frame, first-beat latency
    send_frame(32'h0, 32'h100, N, w);
    push_frame(32'h0, 32'h100);
    check("lat_not_yet", 160'(bus.dout_valid), 160'(0));
    @(posedge clk);
    #1;
    check("lat_valid", 160'(bus.dout_valid), 160'(1));
    check("lat_first_beat", 160'({bus.dout_a_re, bus.dout_b_re, bus.dout_first}),
          160'({32'd0, 32'd32, 1'b1}));
    drain("single_drain");

    // Backpressure: three frames with output blocked
    bus.dout_ready = 1'b0;
    send_frame(32'h1000, 32'h1100, N, w);
    push_frame(32'h1000, 32'h1100);
    send_frame(32'h2000, 32'h2100, N - 1, w);
    check("bp_ready_127", 160'(bus.din_ready), 160'(1));
    send(32'h2000 + 32'(N - 1), 32'h2100 + 32'(N - 1), w);
    push_frame(32'h2000, 32'h2100);
    check("bp_ready_128", 160'(bus.din_ready), 160'(0));
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready_held", 160'(bus.din_ready), 160'(0));
    bus.dout_ready = 1'b1;
    saw = 1'b0;
    guard = 0;
    while (!saw && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
      if (bus.dout_valid && bus.dout_last) begin
        saw = 1'b1;
        check("bp_ready_after_last", 160'(bus.din_ready), 160'(1));
      end else if (bus.din_ready !== 1'b0) begin
        check("bp_ready_early", 160'(bus.din_ready), 160'(0));
      end
    end
    check("bp_saw_last", 160'(saw), 160'(1));
    send_frame(32'h3000, 32'h3100, N, w);
    push_frame(32'h3000, 32'h3100);
    check("bp_frame2_waits", 160'(w), 160'(0));
    drain("bp_drain");

    // Pseudo-random output stalls
    rand_rdy = 1'b1;
    send_frame(32'h4000, 32'h4100, N, w);
    push_frame(32'h4000, 32'h4100);
    send_frame(32'h5000, 32'h5100, N, w);
    push_frame(32'h5000, 32'h5100);
    drain("stall_drain");
    rand_rdy = 1'b0;
    bus.dout_ready = 1'b1;

    // Flush drops the partial frame and the sample presented with it
    send_frame(32'h500, 32'h600, 10, w);
    bus.flush     = 1'b1;
    bus.din_valid = 1'b1;
    bus.din_re    = 32'hdead;
    bus.din_im    = 32'hbeef;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.din_valid = 1'b0;
    send_frame(32'h200, 32'h300, N, w);
    push_frame(32'h200, 32'h300);
    drain("flush_drain");

    // Reset mid-readout with a partial frame pending
    bus.dout_ready = 1'b0;
    send_frame(32'h6000, 32'h6100, N, w);
    push_frame(32'h6000, 32'h6100);
    send_frame(32'h7000, 32'h7100, 40, w);
    base = beats;
    bus.dout_ready = 1'b1;
    guard = 0;
    while (beats < base + 5 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("mid_beats", 160'(beats - base), 160'(5));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.dout_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("mid_rst_status", 160'({bus.din_ready, bus.dout_valid}), 160'(0));
      check("mid_rst_data", 160'(cur_beat()), 160'(0));
    end
    rst = 1'b1;
    exp_q.delete();
    bus.dout_ready = 1'b1;
    #1;
    check("mid_post_ready", 160'(bus.din_ready), 160'(1));
    check("mid_post_valid", 160'(bus.dout_valid), 160'(0));
    send_frame(32'h8000, 32'h8100, N, w);
    push_frame(32'h8000, 32'h8100);
    drain("mid_drain");

    // Continuous throughput: 8 frames back to back
    base = beats;
    base = base;
    begin
      int total = 0;
      for (int f = 0; f < 8; f++) begin
        send_frame(32'h10000 * (f + 1), 32'h10000 * (f + 1) + 32'h100, N, w);
        push_frame(32'h10000 * (f + 1), 32'h10000 * (f + 1) + 32'h100);
        total += w;
      end
      check("thru_waits", 160'(total), 160'(0));
    end
    drain("thru_drain");
    check("thru_beats", 160'(beats - base), 160'(256));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
